regfile_mp: RTL and testbench

Parametrised multi-ported register file, the successor to the fixed 2-read/1-write 64×32 CPU register file. Width, depth and port counts are configurable. Register 0 reads as zero. Reset runs a one-register-per-cycle clear sweep so the array maps onto RAM-style storage. Same-register write collisions are resolved deterministically and flagged. It sits in the decode/writeback stage of the core; it serves the single-issue pipeline with NUM_WR=1 and dual-issue variants with NUM_WR=2.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_clear_seq.sv | 48 ++++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, FSM state type and constants for the multi-ported register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 64;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned NUM_RD_DEF   = 2;
  localparam int unsigned NUM_WR_DEF   = 1;

  // Register index that is hardwired to zero
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every register index once, then holds READY.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_busy,
  output logic              o_clr_en,
  output logic [ADDR_W-1:0] o_clr_addr
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    o_clr_en    = 1'b0;
    case (r_state)
      CLEAR: begin
        o_clr_en  = !i_reset;
        w_idx_nxt = r_idx + ADDR_W'(1);
        if (r_idx == ADDR_W'(NUM_REGS - 1)) w_state_nxt = READY;
      end
      READY:   w_state_nxt = READY;
      default: w_state_nxt = CLEAR;
    endcase
  end

  assign o_busy     = (r_state == CLEAR);
  assign o_clr_addr = r_idx;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-ported register file with x0 hardwired to zero and a post-reset clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter  int unsigned NUM_RD   = NUM_RD_DEF,
  parameter  int unsigned NUM_WR   = NUM_WR_DEF,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     busy,
  output logic                     wr_conflict
);

  logic              w_busy;
  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_ok;
  logic              w_conflict;
  logic              r_conflict;

  logic [ADDR_W-1:0] w_rd_addr [NUM_RD];
  logic [ADDR_W-1:0] w_wr_addr [NUM_WR];
  logic [DATA_W-1:0] w_wr_data [NUM_WR];
  logic [DATA_W-1:0] r_mem     [NUM_REGS];

  regfile_clear_seq #(
    .NUM_REGS (NUM_REGS)
  ) u_clear_seq (
    .i_clk      (clk),
    .i_reset    (reset),
    .o_busy     (w_busy),
    .o_clr_en   (w_clr_en),
    .o_clr_addr (w_clr_addr)
  );

  always_comb begin
    for (int unsigned r = 0; r < NUM_RD; r++) w_rd_addr[r] = rd_addr[r*ADDR_W +: ADDR_W];
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      w_wr_addr[w] = wr_addr[w*ADDR_W +: ADDR_W];
      w_wr_data[w] = wr_data[w*DATA_W +: DATA_W];
    end
  end

  assign w_wr_ok = !w_busy && !reset;

  // Ascending port loop: the last assignment, from the highest-index port, wins
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (w_wr_addr[w] != ADDR_W'(ZERO_REG))) r_mem[w_wr_addr[w]] <= w_wr_data[w];
      end
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      for (int unsigned j = i + 1; j < NUM_WR; j++) begin
        if (wr_en[i] && wr_en[j] && (w_wr_addr[i] == w_wr_addr[j]) &&
            (w_wr_addr[i] != ADDR_W'(ZERO_REG)))
          w_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_conflict <= 1'b0;
    else       r_conflict <= w_wr_ok && w_conflict;
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      if (!w_busy && (w_rd_addr[r] != ADDR_W'(ZERO_REG))) begin
        rd_data[r*DATA_W +: DATA_W] = r_mem[w_rd_addr[r]];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && (w_wr_addr[w] == w_rd_addr[r])) rd_data[r*DATA_W +: DATA_W] = w_wr_data[w];
        end
`endif
      end
    end
  end

  assign busy        = w_busy;
  assign wr_conflict = r_conflict;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized checks of regfile_mp (dual write ports) against an array-based reference model.
module tb_regfile_mp;

  localparam int DW  = 64;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              busy;
  logic              wr_conflict;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD),
    .NUM_WR   (NWR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .wr_conflict (wr_conflict)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: register contents, remaining clear edges, expected conflict flag
  logic [DW-1:0] m_mem [NR];
  int            m_left;
  logic          m_conf;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int a);
    logic [DW-1:0] v;
    if (m_left != 0 || a == 0) return '0;
    v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) v = wr_data[w*DW +: DW];
`endif
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    for (int r = 0; r < NRD; r++)
      chk($sformatf("%s.rd%0d", tag, r), rd_data[r*DW +: DW], exp_rd(int'(rd_addr[r*AW +: AW])));
    chk({tag, ".busy"}, DW'(busy), DW'(m_left != 0));
    chk({tag, ".conflict"}, DW'(wr_conflict), DW'(m_conf));
  endtask

  task automatic tick();
    logic [DW-1:0] nm [NR];
    int            hits [NR];
    int            nleft;
    logic          nconf;
    int            a;
    nm    = m_mem;
    nleft = m_left;
    nconf = 1'b0;
    for (int i = 0; i < NR; i++) hits[i] = 0;
    if (reset) begin
      for (int i = 0; i < NR; i++) nm[i] = '0;
      nleft = NR;
    end else if (m_left != 0) begin
      nleft = m_left - 1;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        a = int'(wr_addr[w*AW +: AW]);
        if (wr_en[w] && a != 0) begin
          nm[a] = wr_data[w*DW +: DW];
          hits[a]++;
          if (hits[a] >= 2) nconf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    m_mem  = nm;
    m_left = nleft;
    m_conf = nconf;
  endtask

  task automatic drive_wr(input int p, input logic en, input int a, input logic [DW-1:0] d);
    wr_en[p]            = en;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic drive_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic idle_wr();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < NR; a++) begin
      drive_rd(0, a);
      drive_rd(1, NR - 1 - a);
      #1;
      check_outputs($sformatf("%s.x%0d", tag, a));
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
    m_left  = NR;
    m_conf  = 1'b0;
    reset   = 1'b1;
    rd_addr = '0;
    idle_wr();

    // Reset state
    tick();
    chk("reset.busy", DW'(busy), DW'(1));
    chk("reset.conflict", DW'(wr_conflict), '0);
    check_outputs("reset");
    reset = 1'b0;

    // Sweep: writes to x3 on both ports are dropped and never flag a conflict
    for (int e = 1; e <= NR; e++) begin
      drive_wr(0, 1'b1, 3, 64'hFF);
      drive_wr(1, 1'b1, 3, 64'hFF);
      drive_rd(0, $urandom_range(0, NR - 1));
      drive_rd(1, 3);
      tick();
      check_outputs($sformatf("sweep%0d", e));
    end
    idle_wr();
    chk("sweep.busy_low", DW'(busy), '0);
    read_all("post_sweep");
    drive_rd(0, 3);
    #1;
    chk("busy_write.x3", rd_data[DW-1:0], '0);

    // Dual-port same-register collision: highest port wins, one-cycle flag
    drive_wr(0, 1'b1, 5, 64'h1111);
    drive_wr(1, 1'b1, 5, 64'h2222);
    tick();
    idle_wr();
    drive_rd(0, 5);
    #1;
    chk("collide.x5", rd_data[DW-1:0], 64'h2222);
    chk("collide.flag", DW'(wr_conflict), DW'(1));
    check_outputs("collide");
    tick();
    chk("collide.flag_drop", DW'(wr_conflict), '0);

    // x0 stays zero and never conflicts
    drive_wr(0, 1'b1, 0, 64'hDEAD);
    drive_wr(1, 1'b1, 0, 64'hDEAD);
    drive_rd(0, 0);
    tick();
    idle_wr();
    chk("x0.read", rd_data[DW-1:0], '0);
    chk("x0.conflict", DW'(wr_conflict), '0);

    // Same-cycle write/read of x7
    drive_wr(0, 1'b1, 7, 64'h1234);
    tick();
    drive_wr(0, 1'b1, 7, 64'hA5A5);
    drive_rd(1, 7);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x7.same_cycle", rd_data[DW +: DW], 64'hA5A5);
`else
    chk("x7.same_cycle", rd_data[DW +: DW], 64'h1234);
`endif
    check_outputs("x7.same");
    tick();
    idle_wr();
    #1;
    chk("x7.next_cycle", rd_data[DW +: DW], 64'hA5A5);

    // Randomized traffic over a narrow address range to provoke collisions
    for (int c = 0; c < 300; c++) begin
      for (int w = 0; w < NWR; w++)
        drive_wr(w, 1'($urandom_range(0, 1)), $urandom_range(0, 7), {$urandom, $urandom});
      for (int r = 0; r < NRD; r++) drive_rd(r, $urandom_range(0, 7));
      #1;
      check_outputs($sformatf("rnd%0d.pre", c));
      tick();
      check_outputs($sformatf("rnd%0d.post", c));
    end
    idle_wr();

    // Fill x1..x31 with their index, then reset mid-sweep at idx=10
    for (int a = 1; a < NR; a++) begin
      drive_wr(1, 1'b1, a, DW'(a));
      tick();
    end
    idle_wr();
    read_all("fill");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 0; e < 10; e++) tick();
    check_outputs("mid_sweep");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= NR; e++) begin
      drive_rd(0, $urandom_range(1, NR - 1));
      tick();
      chk($sformatf("restart%0d.busy", e), DW'(busy), DW'(e < NR));
      check_outputs($sformatf("restart%0d", e));
    end
    read_all("post_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
